// File: rtl/mod_arith_pkg.sv
// Shared modular-arithmetic definitions: the operation mode, the constant
// reduction used at elaboration and the residue width derivation.
package mod_arith_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Bits needed to hold residues 0..m-1 (never less than one bit).
    function automatic int mod_width(input longint m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    // Constant folded into 0..m-1, negative constants wrap upwards.
    function automatic longint reduce_const(input longint c, input longint m);
        longint r;
        r = c % m;
        if (r < 0) begin
            r = r + m;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_add_const_lane.sv
// One residue lane: stage 1 forms the raw sum/difference and its wrapped
// alternative, stage 2 picks the one that lands in range.
// Optional range check on the operand when MOD_ADD_ERR_CHK_EN is defined.
module mod_add_const_lane
    import mod_arith_pkg::*;
#(
    parameter int MODULUS = 17,
    parameter int CONST_R = 0,
    parameter int WIDTH   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_p1,
    input  logic             en_p2,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum,
    output logic             err
);

    // Two guard bits: one for the carry of a + CONST_R, one for the sign.
    localparam int XW = WIDTH + 2;
    localparam logic signed [XW-1:0] M_S = XW'(MODULUS);
    localparam logic signed [XW-1:0] C_S = XW'(CONST_R);

    // Add wraps when the sum reaches M, subtract wraps when it goes negative.
    function automatic logic [WIDTH-1:0] mod_select(input mode_e m,
                                                   input logic signed [XW-1:0] s,
                                                   input logic signed [XW-1:0] t);
        logic wrap;
        wrap = (m == MODE_SUB) ? s[XW-1] : (s >= M_S);
        return wrap ? t[WIDTH-1:0] : s[WIDTH-1:0];
    endfunction

    logic signed [XW-1:0] a_x;
    logic signed [XW-1:0] s_c;
    logic signed [XW-1:0] t_c;
    logic signed [XW-1:0] s_p1;
    logic signed [XW-1:0] t_p1;
    mode_e                mode_p1;
    logic [WIDTH-1:0]     sum_p2;

    assign a_x = signed'(XW'(a));

    // Raw result and its one-modulus correction for the selected mode.
    always_comb begin
        if (mode == MODE_SUB) begin
            s_c = a_x - C_S;
            t_c = s_c + M_S;
        end else begin
            s_c = a_x + C_S;
            t_c = s_c - M_S;
        end
    end

    // ---- stage 1 boundary ----
    // Stage 1 data register, loaded only on an accepted beat.
    always_ff @(posedge clk) begin
        if (en_p1) begin
            s_p1    <= s_c;
            t_p1    <= t_c;
            mode_p1 <= mode;
        end
    end

    // ---- stage 2 boundary ----
    // Stage 2 result register, cleared by reset so the output reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p2 <= '0;
        end else if (en_p2) begin
            sum_p2 <= mod_select(mode_p1, s_p1, t_p1);
        end
    end

    assign sum = sum_p2;

`ifdef MOD_ADD_ERR_CHK_EN
    logic err_p1;
    logic err_p2;

    // Out-of-range operand flag captured alongside the stage 1 data.
    always_ff @(posedge clk) begin
        if (en_p1) begin
            err_p1 <= (a_x >= M_S);
        end
    end

    // Flag follows the beat into stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_p2 <= 1'b0;
        end else if (en_p2) begin
            err_p2 <= err_p1;
        end
    end

    assign err = err_p2;
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/mod_add_const_pipe.sv
// Two-stage pipelined (a +/- CONST) mod MODULUS over NUM_CH lanes with a
// single valid/ready handshake. MOD_ADD_ERR_CHK_EN enables the operand range
// check, out_err and err_sticky; without it those outputs are tied low.
module mod_add_const_pipe
    import mod_arith_pkg::*;
#(
    parameter int MODULUS = 17,
    parameter int CONST   = 0,
    parameter int WIDTH   = mod_width(MODULUS),
    parameter int NUM_CH  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic [NUM_CH*WIDTH-1:0] in_a,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_sum,
    output logic [NUM_CH-1:0]       out_err,
    output logic                    err_sticky,
    input  logic                    err_clr
);

    localparam int CONST_R = int'(reduce_const(CONST, MODULUS));

    logic vld_p1;
    logic vld_p2;
    logic adv_p2;
    logic acc_p0;
    logic en_p2;

    assign adv_p2   = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || adv_p2;
    assign acc_p0   = in_valid && in_ready;
    assign en_p2    = adv_p2 && vld_p1;
    assign out_valid = vld_p2;

    // Valid bits: stage 1 refills whenever it can move, stage 2 on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (in_ready) begin
                vld_p1 <= in_valid;
            end
            if (adv_p2) begin
                vld_p2 <= vld_p1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        mod_add_const_lane #(
            .MODULUS (MODULUS),
            .CONST_R (CONST_R),
            .WIDTH   (WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en_p1 (acc_p0),
            .en_p2 (en_p2),
            .mode  (mode_e'(in_mode)),
            .a     (in_a[k*WIDTH +: WIDTH]),
            .sum   (out_sum[k*WIDTH +: WIDTH]),
            .err   (out_err[k])
        );
    end

`ifdef MOD_ADD_ERR_CHK_EN
    // Sticky error: a flagged consume wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (out_valid && out_ready && (|out_err)) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_mod_add_const_pipe.sv
// Directed and random checks of mod_add_const_pipe with M=17, CONST=5,
// two lanes. Error expectations follow MOD_ADD_ERR_CHK_EN.
module tb_mod_add_const_pipe;

    localparam int M = 17;
    localparam int C = 5;
    localparam int W = 5;
`ifdef MOD_ADD_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2*W-1:0] sum;
        logic [1:0]     err;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           in_mode;
    logic [2*W-1:0] in_a;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_sum;
    logic [1:0]     out_err;
    logic           err_sticky;
    logic           err_clr;

    int   n_pass  = 0;
    int   n_total = 0;
    int   n_out   = 0;
    int   cyc     = 0;
    bit   rnd_rdy = 1'b0;
    exp_t sb[$];
    bit             hold_p = 1'b0;
    logic [2*W-1:0] hold_sum;
    logic [1:0]     hold_err;

    mod_add_const_pipe #(
        .MODULUS (M),
        .CONST   (C),
        .NUM_CH  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_a       (in_a),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_err    (out_err),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [2*W-1:0] a, input logic m);
        exp_t e;
        e = '0;
        for (int k = 0; k < 2; k++) begin
            int v;
            int r;
            v = int'(a[k*W +: W]);
            if (m == 1'b0) begin
                r = v + C;
                if (r >= M) r = r - M;
            end else begin
                r = v - C;
                if (r < 0) r = r + M;
            end
            e.sum[k*W +: W] = r[W-1:0];
            e.err[k]        = ERR_EN && (v >= M);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output side: hold stability, scoreboard pop on consume, push on accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            hold_p = 1'b0;
        end else begin
            if (hold_p) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_sum", 32'(out_sum), 32'(hold_sum));
                check("hold_err", 32'(out_err), 32'(hold_err));
            end
            hold_p   = out_valid && !out_ready;
            hold_sum = out_sum;
            hold_err = out_err;
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_sum", 32'(out_sum), 32'(e.sum));
                    check("sb_err", 32'(out_err), 32'(e.err));
                    n_out++;
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_a, in_mode));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W-1:0] a0, input logic [W-1:0] a1, input logic m);
        in_valid = 1'b1;
        in_a     = {a1, a0};
        in_mode  = m;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                return;
            end
            tick();
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            tick();
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_a      = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Add {3,12} -> {8,0} with two-cycle latency
        send(5'd3, 5'd12, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("add_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("add_lat2_valid", 32'(out_valid), 32'd1);
        check("add_sum", 32'(out_sum), 32'({5'd0, 5'd8}));
        tick();

        // Subtract {2,16} -> {14,11}
        send(5'd2, 5'd16, 1'b1);
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        check("sub_valid", 32'(out_valid), 32'd1);
        check("sub_sum", 32'(out_sum), 32'({5'd11, 5'd14}));
        tick();

        // Wrap boundaries in both directions
        send(5'd12, 5'd16, 1'b0);
        send(5'd0, 5'd4, 1'b1);
        send(5'd11, 5'd5, 1'b0);
        send(5'd5, 5'd6, 1'b1);
        drain();

        // Stall: two beats enter, then in_ready drops while output is held
        out_ready = 1'b0;
        send(5'd1, 5'd2, 1'b0);
        send(5'd7, 5'd15, 1'b1);
        in_valid = 1'b1;
        in_a     = {5'd9, 5'd10};
        in_mode  = 1'b0;
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        tick();
        @(negedge clk);
        check("stall_in_ready2", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b1;
        send(5'd10, 5'd9, 1'b0);
        send(5'd4, 5'd13, 1'b1);
        drain();

        // Full throughput: eight back-to-back beats, eight consecutive results
        c0 = cyc;
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            send(5'(i), 5'(16 - i), 1'(i % 2));
        end
        check("stream_in_cycles", 32'(cyc - c0), 32'd8);
        in_valid = 1'b0;
        tick();
        tick();
        check("stream_out_count", 32'(n_out - n0), 32'd8);
        drain();

        // Reset with two beats in flight
        send(5'd1, 5'd1, 1'b0);
        send(5'd2, 5'd2, 1'b1);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_sum", 32'(out_sum), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_stale", 32'(out_valid), 32'd0);
            tick();
        end
        @(negedge clk);
        check("rst_rel_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Range error on lane 0, sticky behaviour and clear priority
        send(5'd20, 5'd3, 1'b0);
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        check("err_out_err", 32'(out_err), ERR_EN ? 32'd1 : 32'd0);
        check("err_sum", 32'(out_sum), 32'({5'd8, 5'd8}));
        check("err_sticky_pre", 32'(err_sticky), 32'd0);
        tick();
        @(negedge clk);
        check("err_sticky_set", 32'(err_sticky), 32'(ERR_EN));
        tick();
        @(negedge clk);
        check("err_sticky_keep", 32'(err_sticky), 32'(ERR_EN));
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("err_sticky_clr", 32'(err_sticky), 32'd0);
        tick();
        send(5'd3, 5'd20, 1'b0);
        in_valid = 1'b0;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("err_set_over_clr", 32'(err_sticky), 32'(ERR_EN));
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("err_sticky_clr2", 32'(err_sticky), 32'd0);
        tick();

        // Random in-range traffic with random backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] r0;
            logic [W-1:0] r1;
            logic         rm;
            r0 = W'($urandom_range(0, M - 1));
            r1 = W'($urandom_range(0, M - 1));
            rm = 1'($urandom_range(0, 1));
            send(r0, r1, rm);
        end
        rnd_rdy   = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
